// File: rtl/instr_fetch_if.sv
// Purpose : bundles the IF-stage control inputs, instruction-ROM port and IF/ID outputs.
// Latency : none, wires only.
// Backpressure: stall and flush travel in from the hazard unit and are consumed by the master.
// Ports (master = fetch unit):
//   in  stall, flush, redirect, redirect_pc, imem_instr
//   out imem_addr, if_id_valid, if_id_pc, if_id_instr, fault, fault_pc
interface instr_fetch_if #(
  parameter int ADDR_W = 64
);
  logic              stall;
  logic              flush;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              if_id_valid;
  logic [ADDR_W-1:0] if_id_pc;
  logic [31:0]       if_id_instr;
  logic              fault;
  logic [ADDR_W-1:0] fault_pc;

  modport master (
    input  stall, flush, redirect, redirect_pc, imem_instr,
    output imem_addr, if_id_valid, if_id_pc, if_id_instr, fault, fault_pc
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, imem_instr,
    input  imem_addr, if_id_valid, if_id_pc, if_id_instr, fault, fault_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose : IF stage; owns the PC, reads the zero-latency ROM and fills the IF/ID register.
// Latency : imem_instr at imem_addr is captured into IF/ID on the same posedge.
// Backpressure: stall holds PC and IF/ID; flush bubbles IF/ID; a bad PC halts fetch until reset.
// Ports:
//   clk, reset (async, active-high)
//   bus (instr_fetch_if.master): control in, ROM address/data, IF/ID and fault status out
module instr_fetch_unit #(
  parameter int                ADDR_W    = 64,
  parameter int                MEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_if.master        bus
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);
  localparam logic [ADDR_W-1:0] WORD      = ADDR_W'(4);

  logic [ADDR_W-1:0] pc;
  logic              fault;
  logic [ADDR_W-1:0] fault_pc;
  logic              ifid_valid;
  logic [ADDR_W-1:0] ifid_pc;
  logic [31:0]       ifid_instr;

  logic              pc_ok;
  logic              fault_set;

  // Bound check compares against the last word address directly so the
  // test never has to form pc+3, which could wrap at the top of the space.
  assign pc_ok     = (pc[1:0] == 2'b00) && (pc <= LAST_WORD);
  // A redirect in the same cycle replaces the bad PC before it can fault.
  assign fault_set = !fault && !pc_ok && !bus.redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      if (fault_set) begin
        fault    <= 1'b1;
        fault_pc <= pc;
      end
      // Once faulted (or faulting now) the PC is frozen, redirects included.
      if (!(fault || fault_set)) begin
        if (bus.redirect) begin
          pc <= bus.redirect_pc;
        end else if (!bus.stall) begin
          pc <= pc + WORD;
        end
      end
    end
  end

  // A redirect without flush still lets the sequential word enter IF/ID;
  // that word is the delay slot and the hazard unit flushes it if needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (bus.flush) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (bus.stall) begin
      ifid_valid <= ifid_valid;
      ifid_pc    <= ifid_pc;
      ifid_instr <= ifid_instr;
    end else if (fault || !pc_ok) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else begin
      ifid_valid <= 1'b1;
      ifid_pc    <= pc;
      ifid_instr <= bus.imem_instr;
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_id_valid = ifid_valid;
  assign bus.if_id_pc    = ifid_pc;
  assign bus.if_id_instr = ifid_instr;
  assign bus.fault       = fault;
  assign bus.fault_pc    = fault_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : directed vector bench for instr_fetch_unit with a combinational ROM model.
// Latency : outputs sampled 1 ns after each posedge.
// Backpressure: stall/flush/redirect driven from the vector table.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 64;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .MEM_BYTES(1024),
    .RESET_PC ('0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ROM model: word i holds 0x1000 + i.
  assign bus.imem_instr = 32'h1000 + 32'(bus.imem_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              stall;
    logic              flush;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] e_addr;
    logic              e_valid;
    logic [ADDR_W-1:0] e_pc;
    logic [31:0]       e_instr;
    logic              e_fault;
    logic [ADDR_W-1:0] e_fault_pc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] e_addr, input logic e_valid,
                         input logic [63:0] e_pc, input logic [31:0] e_instr,
                         input logic e_fault, input logic [63:0] e_fault_pc);
    chk({tag, ".imem_addr"},   bus.imem_addr,   e_addr);
    chk({tag, ".if_id_valid"}, 64'(bus.if_id_valid), 64'(e_valid));
    chk({tag, ".if_id_pc"},    bus.if_id_pc,    e_pc);
    chk({tag, ".if_id_instr"}, 64'(bus.if_id_instr), 64'(e_instr));
    chk({tag, ".fault"},       64'(bus.fault),  64'(e_fault));
    chk({tag, ".fault_pc"},    bus.fault_pc,    e_fault_pc);
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [63:0] rpc);
    bus.stall       = s;
    bus.flush       = f;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [63:0] rpc,
                              input logic [63:0] a, input logic v, input logic [63:0] p,
                              input logic [31:0] i, input logic fl, input logic [63:0] fp);
    vec_t t;
    t.stall = s; t.flush = f; t.redirect = r; t.redirect_pc = rpc;
    t.e_addr = a; t.e_valid = v; t.e_pc = p; t.e_instr = i;
    t.e_fault = fl; t.e_fault_pc = fp;
    return t;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //          stl flu red rpc      addr  vld pc    instr     flt fpc
    vecs[0]  = mk(0, 0, 0, 64'h0,   64'd4,  1, 64'd0,  32'h1000, 0, 64'h0);
    vecs[1]  = mk(0, 0, 0, 64'h0,   64'd8,  1, 64'd4,  32'h1001, 0, 64'h0);
    vecs[2]  = mk(1, 0, 0, 64'h0,   64'd8,  1, 64'd4,  32'h1001, 0, 64'h0);
    vecs[3]  = mk(1, 0, 0, 64'h0,   64'd8,  1, 64'd4,  32'h1001, 0, 64'h0);
    vecs[4]  = mk(0, 0, 0, 64'h0,   64'd12, 1, 64'd8,  32'h1002, 0, 64'h0);
    vecs[5]  = mk(0, 1, 1, 64'h40,  64'h40, 0, 64'h0,  32'h0,    0, 64'h0);
    vecs[6]  = mk(0, 0, 0, 64'h0,   64'h44, 1, 64'h40, 32'h1010, 0, 64'h0);
    vecs[7]  = mk(1, 0, 1, 64'h80,  64'h80, 1, 64'h40, 32'h1010, 0, 64'h0);
    vecs[8]  = mk(0, 0, 0, 64'h0,   64'h84, 1, 64'h80, 32'h1020, 0, 64'h0);
    vecs[9]  = mk(1, 1, 0, 64'h0,   64'h84, 0, 64'h0,  32'h0,    0, 64'h0);
    vecs[10] = mk(0, 0, 1, 64'h42,  64'h42, 1, 64'h84, 32'h1021, 0, 64'h0);
    vecs[11] = mk(0, 0, 1, 64'h48,  64'h48, 0, 64'h0,  32'h0,    0, 64'h0);
    vecs[12] = mk(0, 0, 1, 64'h42,  64'h42, 1, 64'h48, 32'h1012, 0, 64'h0);
    vecs[13] = mk(0, 0, 0, 64'h0,   64'h42, 0, 64'h0,  32'h0,    1, 64'h42);
    vecs[14] = mk(0, 0, 1, 64'h0,   64'h42, 0, 64'h0,  32'h0,    1, 64'h42);
    vecs[15] = mk(0, 0, 0, 64'h0,   64'h42, 0, 64'h0,  32'h0,    1, 64'h42);

    drive(0, 0, 0, '0);
    reset = 1'b1;
    #2;
    chk_all("reset", 64'd0, 0, 64'd0, 32'h0, 0, 64'd0);
    #6;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].redirect_pc);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc,
              vecs[i].e_instr, vecs[i].e_fault, vecs[i].e_fault_pc);
    end

    // Run off the end of the ROM: re-init, jump to 1016 and free-run.
    #3;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(0, 1, 1, 64'd1016);
    step();
    chk_all("end_jump", 64'd1016, 0, 64'd0, 32'h0, 0, 64'd0);
    drive(0, 0, 0, '0);
    step();
    chk_all("end_1016", 64'd1020, 1, 64'd1016, 32'h10FE, 0, 64'd0);
    step();
    chk_all("end_1020", 64'd1024, 1, 64'd1020, 32'h10FF, 0, 64'd0);
    step();
    chk_all("end_fault", 64'd1024, 0, 64'd0, 32'h0, 1, 64'd1024);

    // Asynchronous reset between edges while faulted.
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 64'd0, 0, 64'd0, 32'h0, 0, 64'd0);
    #1;
    reset = 1'b0;
    step();
    chk_all("resume0", 64'd4, 1, 64'd0, 32'h1000, 0, 64'd0);
    step();
    chk_all("resume1", 64'd8, 1, 64'd4, 32'h1001, 0, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
IF stage of the 5-stage pipelined ARM CPU. It is the initiator/reader side of the word-addressed instruction ROM interface: it owns the PC, drives the byte address into instructmem, and captures the returned 32-bit instruction into the IF/ID pipeline register. It handles stall, flush, branch redirect, and a sticky fetch-fault halt for misaligned or out-of-bounds PCs.

Parameters:
ADDR_W, 64, width of PC and memory byte address
MEM_BYTES, 1024, instruction memory size in bytes (power of two, >4)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard stall: hold PC and IF/ID
flush  in  1  squash IF/ID (load bubble)
redirect  in  1  taken branch: load PC from redirect_pc
redirect_pc  in  ADDR_W  branch target byte address
imem_addr  out  ADDR_W  byte address to instruction memory
imem_instr  in  32  combinational read data from instruction memory
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  ADDR_W  PC of the IF/ID instruction
if_id_instr  out  32  IF/ID instruction word
fault  out  1  sticky fetch fault, fetch halted
fault_pc  out  ADDR_W  PC that caused the fault

Behaviour:
- Reset (async, active-high): pc=RESET_PC; if_id_valid=0, if_id_pc=0, if_id_instr=0; fault=0, fault_pc=0. Takes effect immediately, with no clock edge required, including mid-operation.
- imem_addr = pc, combinational. Memory read is zero-latency, so the IF/ID register captures imem_instr at the same posedge.
- pc_ok = (pc[1:0]==0) && (pc <= MEM_BYTES-4). The comparison is unsigned and full-width; never compute pc+3, so it cannot overflow.
- Fault set: at a posedge with fault==0, !pc_ok and !redirect, set fault=1 and fault_pc=pc. A redirect in that cycle rescues a bad PC. Fault is cleared only by reset.
- PC update per posedge, highest priority first:
  1. fault==1 or fault being set: hold; redirect is ignored.
  2. redirect: pc<=redirect_pc, even if stall is asserted.
  3. stall: hold.
  4. else pc<=pc+4, modulo 2^ADDR_W.
- IF/ID update per posedge, highest priority first:
  1. flush: valid<=0, pc<=0, instr<=0.
  2. stall: hold all three fields.
  3. fault==1 or !pc_ok: bubble (valid, pc, instr all 0).
  4. else valid<=1, if_id_pc<=pc, if_id_instr<=imem_instr.
- redirect without flush: IF/ID still captures the current, sequential instruction, which acts as a delay slot. The hazard unit asserts flush with redirect when that instruction must be squashed.
- redirect+stall: PC is redirected and IF/ID is held. On the next unstalled edge, the target instruction is fetched.
- flush+stall: flush wins; IF/ID becomes a bubble.
- Sequential run off the end: the word at MEM_BYTES-4 is fetched validly. The pc then becomes MEM_BYTES and the fault is set on the following edge.
- imem_addr keeps being driven while faulted and is frozen at fault_pc.

Test Plan:
1. Reset, release, 3 edges with a ROM model (mem[i]=0x1000+i) -> if_id_pc 0,4,8 with valid=1; if_id_instr 0x1000,0x1001,0x1002; imem_addr=12.
2. With pc=8 and IF/ID pc=4, assert stall for 2 edges -> imem_addr stays 8 and if_id_pc stays 4. After release, the next edge gives if_id_pc=8 and imem_addr=12.
3. redirect=1, redirect_pc=0x40, flush=1 for one edge at pc=12 -> imem_addr=0x40 and if_id_valid=0. The next edge gives if_id_pc=0x40, valid=1.
4. redirect to 0x42 -> imem_addr=0x42. The next edge gives fault=1, fault_pc=0x42, if_id_valid=0. A later redirect to 0 leaves imem_addr at 0x42 and fault at 1.
5. Free-run from 1016 with MEM_BYTES=1024 -> if_id_pc=1020 valid. Then imem_addr=1024, fault=1 next edge, fault_pc=1024, if_id_valid=0.
6. Assert reset mid-run between clock edges while faulted -> all outputs return to their reset values immediately (imem_addr=RESET_PC, fault=0). After release, fetching resumes from 0.
